signed_frame_accumulator: RTL and testbench
===========================================

# signed_frame_accumulator

Streaming two's-complement accumulator: sums a frame of signed W-bit samples delivered over a valid/ready input and presents one W-bit result per frame. The result carries a sticky signed-overflow flag and a sample count. This is the parametrised, sequential successor to our fixed 8-bit signed adder-with-overflow. It sits between sample producers and downstream statistics or checksum logic. Optional saturating arithmetic replaces wrap-around.

## Interface
- W, 8, sample and accumulator width (bits, ≥2)
- CW, 8, sample-counter width (bits, ≥1)

- clk  in  1  rising-edge clock
- aresetn  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: discard the current frame and any pending result
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  W  signed sample
- in_last  in  1  sample is the final one of its frame
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  W  signed frame sum
- out_overflow  out  1  signed overflow occurred in at least one add of the frame
- out_count  out  CW  accepted samples in the frame, saturating at 2^CW−1

## Operation
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- States:
  - ACC: accumulating; in_ready=1. Idle is ACC with count 0.
  - HOLD: result presented; in_ready=0, out_valid=1.
- Accept = in_valid && in_ready.
- Per accepted sample: sum = acc + in_data, computed modulo 2^W.
- Overflow per add: ov = (acc[W-1] == in_data[W-1]) && (sum[W-1] != acc[W-1]).
- On accept:
  - acc <= sum.
  - ovf <= ovf | ov.
  - count <= count+1, held at all-ones once reached.
- Accept with in_last=1: ACC→HOLD.
- In HOLD, out_valid && out_ready:
  - acc, ovf and count clear to 0.
  - HOLD→ACC.
- clear=1:
  - State becomes ACC; acc, ovf and count clear.
  - Any accept or output handshake in the same cycle is ignored.
- A frame may be a single sample (in_last on the first sample).
- The first sample of a frame is added to 0, so it alone never overflows.

## Timing
- Reset values: state ACC, acc=0, ovf=0, count=0, in_ready=1, out_valid=0, out_sum=0, out_overflow=0, out_count=0.
- Reset mid-frame or in HOLD drops everything immediately (asynchronous).
- Accumulation throughput: one sample per cycle.
- Latency: out_valid rises in the cycle after the accept with in_last.
- out_sum, out_overflow and out_count come directly from registers. They are stable while out_valid=1 and out_ready=0, and are equal to the current register values in every state.
- No bypass:
  - in_ready rises in the cycle after the output handshake.
  - The minimum frame-to-frame gap is one cycle with in_ready=0.
- in_data and in_last are ignored when no accept occurs.
- out_valid never drops without a handshake, clear or reset.

## Configuration
- SIGNED_ACC_SAT_EN defined:
  - An add with ov=1 stores 2^(W-1)−1 if in_data is non-negative, or −2^(W-1) if negative.
  - Later adds proceed from the clamped value.
  - ovf is still set.
- Undefined: the wrapped modulo-2^W sum is stored.
- Handshake, count and the overflow flag are identical in both builds.

## Structure
- Package signed_acc_pkg holds:
  - state enum (ACC, HOLD);
  - function for the overflow predicate;
  - function returning the saturation limits for a given W.
- One sub-module, signed_add_ovf: combinational W-bit add producing sum and ov, with optional clamp via SIGNED_ACC_SAT_EN. The top level holds the FSM, registers and counter.

## Test plan
- W=8. Frame 0x64, 0x1E(last) → out_sum=0x82, out_overflow=1, out_count=2. With SAT_EN: out_sum=0x7F.
- W=8. Frame 0x80, 0xFF(last) → 0x7F, overflow=1. With SAT_EN: 0x80.
- W=8. Frame 0x7F, 0x80(last) → 0xFF, overflow=0. Mixed signs never overflow.
- W=8. Frame 0x64, 0x64, 0x9C(last) → wrap build: 0x64 with sticky overflow=1. SAT_EN build: 0x1B with overflow=1. Count=3.
- Result with out_ready held low 3 cycles → out_valid and outputs stable, in_ready=0 throughout. Handshake → in_ready=1 the next cycle, count=0.
- clear after 2 samples → next frame 0x05(last) gives 0x05, overflow=0, count=1. Also check aresetn low during HOLD gives every reset value immediately.

Source files
------------

// File: rtl/signed_acc_pkg.sv
// Shared types and helpers for the signed frame accumulator.
// Holds the FSM state enum, the signed-overflow predicate and the
// saturation limits for a given accumulator width (up to MAX_W bits).
package signed_acc_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Two's-complement add overflows only when both operands share a sign
  // and the result's sign differs from it.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Largest positive value of a w-bit signed number, 2^(w-1)-1.
  function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i + 1 < w) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Most negative value of a w-bit signed number, -2^(w-1).
  function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i + 1 == w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/signed_add_ovf.sv
// Combinational W-bit two's-complement adder with overflow detect.
// Build option SIGNED_ACC_SAT_EN: on overflow the sum clamps to the
// signed limit in the direction of operand b; otherwise it wraps.
// Ports: a, b   - signed operands (a is the running accumulator)
//        sum_c  - stored result (wrapped or clamped)
//        ov_c   - signed overflow of the raw add
module signed_add_ovf
  import signed_acc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum_c,
  output logic         ov_c
);

  logic [W-1:0] raw;

  always_comb begin
    raw   = a + b;
    ov_c  = add_ovf(a[W-1], b[W-1], raw[W-1]);
    sum_c = raw;
`ifdef SIGNED_ACC_SAT_EN
    // Overflow implies a and b share a sign, so b's sign picks the limit.
    if (ov_c) begin
      sum_c = b[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
    end
`endif
  end

endmodule

// File: rtl/signed_frame_accumulator.sv
// Streaming signed frame accumulator: sums a frame of signed W-bit samples
// received over valid/ready and presents one result per frame with a sticky
// overflow flag and a saturating sample count.
// Build option SIGNED_ACC_SAT_EN: saturating adds instead of wrap-around.
// Ports: clk, aresetn (async active-low), clear (sync abort)
//        in_valid/in_ready/in_data/in_last  - sample stream
//        out_valid/out_ready                - result handshake
//        out_sum/out_overflow/out_count     - result registers
module signed_frame_accumulator
  import signed_acc_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_overflow,
  output logic [CW-1:0] out_count
);

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  add_sum_c;
  logic          add_ov_c;

  signed_add_ovf #(.W(W)) u_add (
    .a     (acc_q),
    .b     (in_data),
    .sum_c (add_sum_c),
    .ov_c  (add_ov_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; clear overrides any handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            acc_d = add_sum_c;
            ovf_d = ovf_q | add_ov_c;
            if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
            if (in_last) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // Outputs are direct decodes/copies of registers.
  assign in_ready     = (state_q == ACC);
  assign out_valid    = (state_q == HOLD);
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Directed self-checking bench for signed_frame_accumulator (W=8, CW=8).
// Expected values follow the build: SIGNED_ACC_SAT_EN selects clamped sums.
module tb_signed_frame_accumulator;

`ifdef SIGNED_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       aresetn;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_overflow;
  logic [7:0] out_count;

  int checks = 0;
  int failures = 0;

  signed_frame_accumulator #(.W(8), .CW(8)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  // Present one sample for one clock, then idle the bus.
  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00 ||
        out_overflow !== 1'b0 || out_count !== 8'h00) begin
      failures++;
      $display("FAIL reset rdy=%b vld=%b sum=%h ov=%b cnt=%h exp rdy=1 vld=0 sum=00 ov=0 cnt=00",
               in_ready, out_valid, out_sum, out_overflow, out_count);
    end
    #11 aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ovf_pos();
    logic [7:0] exp_sum;
    exp_sum = SAT ? 8'h7F : 8'h82;
    send(8'h64, 1'b0);
    send(8'h1E, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL pos_latency vld=%b rdy=%b exp vld=1 rdy=0", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== exp_sum || out_overflow !== 1'b1 || out_count !== 8'd2) begin
      failures++;
      $display("FAIL pos_ovf sum=%h ov=%b cnt=%0d exp sum=%h ov=1 cnt=2",
               out_sum, out_overflow, out_count, exp_sum);
    end
    handshake();
  endtask

  task automatic test_ovf_neg();
    logic [7:0] exp_sum;
    exp_sum = SAT ? 8'h80 : 8'h7F;
    send(8'h80, 1'b0);
    send(8'hFF, 1'b1);
    checks++;
    if (out_sum !== exp_sum || out_overflow !== 1'b1 || out_count !== 8'd2) begin
      failures++;
      $display("FAIL neg_ovf sum=%h ov=%b cnt=%0d exp sum=%h ov=1 cnt=2",
               out_sum, out_overflow, out_count, exp_sum);
    end
    handshake();
  endtask

  task automatic test_mixed();
    send(8'h7F, 1'b0);
    send(8'h80, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'hFF || out_overflow !== 1'b0 ||
        out_count !== 8'd2) begin
      failures++;
      $display("FAIL mixed vld=%b sum=%h ov=%b cnt=%0d exp vld=1 sum=ff ov=0 cnt=2",
               out_valid, out_sum, out_overflow, out_count);
    end
    handshake();
  endtask

  task automatic test_sticky();
    logic [7:0] exp_sum;
    exp_sum = SAT ? 8'h1B : 8'h64;
    send(8'h64, 1'b0);
    send(8'h64, 1'b0);
    send(8'h9C, 1'b1);
    checks++;
    if (out_sum !== exp_sum || out_overflow !== 1'b1 || out_count !== 8'd3) begin
      failures++;
      $display("FAIL sticky sum=%h ov=%b cnt=%0d exp sum=%h ov=1 cnt=3",
               out_sum, out_overflow, out_count, exp_sum);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    send(8'h10, 1'b0);
    send(8'h20, 1'b1);
    // Offer a sample while holding; it must not be taken.
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'h30 ||
          out_overflow !== 1'b0 || out_count !== 8'd2) begin
        failures++;
        $display("FAIL hold_stable[%0d] vld=%b rdy=%b sum=%h ov=%b cnt=%0d exp vld=1 rdy=0 sum=30 ov=0 cnt=2",
                 i, out_valid, in_ready, out_sum, out_overflow, out_count);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0 ||
        out_sum !== 8'h00) begin
      failures++;
      $display("FAIL after_hs rdy=%b vld=%b cnt=%0d sum=%h exp rdy=1 vld=0 cnt=0 sum=00",
               in_ready, out_valid, out_count, out_sum);
    end
  endtask

  task automatic test_back_to_back();
    send(8'h01, 1'b1);
    // Next frame's first sample offered during the output handshake.
    in_valid = 1'b1; in_data = 8'h02; in_last = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0) begin
      failures++;
      $display("FAIL b2b_gap rdy=%b vld=%b cnt=%0d exp rdy=1 vld=0 cnt=0",
               in_ready, out_valid, out_count);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'h02 || out_count !== 8'd1 ||
        out_overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_frame vld=%b sum=%h cnt=%0d ov=%b exp vld=1 sum=02 cnt=1 ov=0",
               out_valid, out_sum, out_count, out_overflow);
    end
    handshake();
  endtask

  task automatic test_clear();
    send(8'h70, 1'b0);
    send(8'h70, 1'b0);
    // Clear wins over a simultaneous accept with in_last.
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00 ||
        out_overflow !== 1'b0 || out_count !== 8'd0) begin
      failures++;
      $display("FAIL clear rdy=%b vld=%b sum=%h ov=%b cnt=%0d exp rdy=1 vld=0 sum=00 ov=0 cnt=0",
               in_ready, out_valid, out_sum, out_overflow, out_count);
    end
    send(8'h05, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'h05 || out_overflow !== 1'b0 ||
        out_count !== 8'd1) begin
      failures++;
      $display("FAIL post_clear vld=%b sum=%h ov=%b cnt=%0d exp vld=1 sum=05 ov=0 cnt=1",
               out_valid, out_sum, out_overflow, out_count);
    end
    // Clear in HOLD beats a simultaneous output handshake too.
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'h00) begin
      failures++;
      $display("FAIL clear_hold vld=%b rdy=%b sum=%h exp vld=0 rdy=1 sum=00",
               out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_count_sat();
    logic [7:0] exp_sum;
    exp_sum = SAT ? 8'h7F : 8'h00;
    for (int i = 0; i < 255; i++) send(8'h01, 1'b0);
    send(8'h01, 1'b1);
    checks++;
    if (out_count !== 8'hFF || out_sum !== exp_sum || out_overflow !== 1'b1) begin
      failures++;
      $display("FAIL count_sat cnt=%h sum=%h ov=%b exp cnt=ff sum=%h ov=1",
               out_count, out_sum, out_overflow, exp_sum);
    end
    handshake();
  endtask

  task automatic test_async_reset();
    send(8'h64, 1'b0);
    send(8'h1E, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_hold vld=%b exp 1", out_valid);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00 ||
        out_overflow !== 1'b0 || out_count !== 8'h00) begin
      failures++;
      $display("FAIL async_reset rdy=%b vld=%b sum=%h ov=%b cnt=%h exp rdy=1 vld=0 sum=00 ov=0 cnt=00",
               in_ready, out_valid, out_sum, out_overflow, out_count);
    end
    #2 aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ovf_pos();
    test_ovf_neg();
    test_mixed();
    test_sticky();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_count_sat();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
